// File: rtl/inst_prefetch_buf_if.sv
// Instruction-memory request/response bus: prefetch buffer is the master, imem the slave.
interface inst_prefetch_buf_if #(
  parameter int ADD_WIDTH  = 6,
  parameter int INST_WIDTH = 32
) ();
  logic                  imem_req;
  logic [ADD_WIDTH-1:0]  imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch FIFO in front of IF/ID: in-order fetch, redirect flush and drain of stale responses.
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module inst_prefetch_buf #(
  parameter int ADD_WIDTH  = 6,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  inst_prefetch_buf_if.master   imem,
  input  logic                  Stall,
  input  logic                  J,
  input  logic [ADD_WIDTH-1:0]  PC_J_add,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] Inst_out,
  output logic [ADD_WIDTH-1:0]  PC_out,
  output logic                  Ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [ADD_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [OUT_W-1:0]     outstanding_reg, outstanding_next;
  logic [OUT_W-1:0]     discard_reg, discard_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [TAG_W-1:0]     tag_wr_reg, tag_wr_next;
  logic [TAG_W-1:0]     tag_rd_reg, tag_rd_next;

  logic [ADD_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADD_WIDTH-1:0]  tag_mem  [MAX_OUT];

  logic                 run, credit_ok, req, grant;
  logic                 rsp_live, byp, head_valid, out_valid;
  logic                 push, fifo_pop;
  logic [ADD_WIDTH-1:0] rsp_pc;
  logic [OUT_W-1:0]     retire;
  logic [CNT_W:0]       credit_used;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUT - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  assign run         = (state_reg == ST_RUN);
  assign head_valid  = (count_reg != '0);
  assign rsp_pc      = tag_mem[tag_rd_reg];
  assign retire      = OUT_W'(imem.imem_rvalid);

  // Every buffered or in-flight word holds a slot, so a returning response always fits.
  assign credit_used = {1'b0, count_reg} + (CNT_W + 1)'(outstanding_reg);
  assign credit_ok   = (credit_used < (CNT_W + 1)'(DEPTH)) &&
                       (outstanding_reg < OUT_W'(MAX_OUT));
  assign req         = run && !J && credit_ok;
  assign grant       = req && imem.imem_gnt;

  // Only responses of the current stream (RUN, no redirect this cycle) reach decode.
  assign rsp_live    = imem.imem_rvalid && run && !J;
`ifdef PREFETCH_BYPASS_EN
  assign byp         = rsp_live && !head_valid;
`else
  assign byp         = 1'b0;
`endif
  assign out_valid   = head_valid || byp;
  assign fifo_pop    = head_valid && !Stall && !J;
  assign push        = rsp_live && !(byp && !Stall);

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + OUT_W'(grant) - retire;
    count_next       = count_reg + CNT_W'(push) - CNT_W'(fifo_pop);
    wr_ptr_next      = push     ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next      = fifo_pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    tag_wr_next      = grant    ? tag_inc(tag_wr_reg) : tag_wr_reg;
    tag_rd_next      = imem.imem_rvalid ? tag_inc(tag_rd_reg) : tag_rd_reg;
    if (grant) begin
      fetch_pc_next = fetch_pc_reg + ADD_WIDTH'(4);
    end

    case (state_reg)
      ST_RUN: begin
        if (J) begin
          // A response retiring in the redirect cycle is already dropped, so it is not counted.
          discard_next = outstanding_reg - retire;
          if (discard_next != '0) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        discard_next = discard_reg - retire;
        if (discard_next == '0) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase

    if (J) begin
      fetch_pc_next = PC_J_add;
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg       <= ST_RUN;
      fetch_pc_reg    <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tag_wr_reg      <= '0;
      tag_rd_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      tag_wr_reg      <= tag_wr_next;
      tag_rd_reg      <= tag_rd_next;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= rsp_pc;
      inst_mem[wr_ptr_reg] <= imem.imem_rdata;
    end
    if (grant) begin
      tag_mem[tag_wr_reg] <= fetch_pc_reg;
    end
  end

  assign imem.imem_req  = Rst && req;
  assign imem.imem_addr = fetch_pc_reg;
  assign inst_valid     = Rst && out_valid;
  assign Ready          = Rst && run;

  always_comb begin
    Inst_out = '0;
    PC_out   = '0;
    if (inst_valid) begin
      if (byp) begin
        Inst_out = imem.imem_rdata;
        PC_out   = rsp_pc;
      end else begin
        Inst_out = inst_mem[rd_ptr_reg];
        PC_out   = pc_mem[rd_ptr_reg];
      end
    end
  end

  a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst)
    !(push && !fifo_pop && (count_reg == CNT_W'(DEPTH))));

endmodule
